// File: rtl/rd53_link_pkg.sv
// rtl/rd53_link_pkg.sv - shared constants and types for the RD53 link framing path
//
// Shared by the header seeker and the frame extractor:
//   c_DATA_HEADER / c_CMD_HEADER : the two legal 2-bit frame headers
//   FRAME_W                      : 66-bit frame (2-bit header + 64-bit payload)
//   SLICE_W                      : 67-bit gearbox window slice
//   lock_state_t                 : lock-maintenance FSM states
//   frame_t                      : header/payload view of one frame
package rd53_link_pkg;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;

  localparam int FRAME_W = 66;
  localparam int SLICE_W = 67;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    RESYNC,
    WAIT_DESYNC
  } lock_state_t;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } frame_t;

  // Only 01 (data) and 10 (command) are legal sync headers.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/frame_lock_fsm.sv
// rtl/frame_lock_fsm.sv - lock-maintenance FSM with header-error monitoring
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   is_synced      : seeker sync flag
//   frame_vld_i    : a frame is being emitted this cycle
//   frame_hdr_i    : header of that frame
//   state_o        : current lock state
//   locked_o       : state is LOCKED
//   resync_o       : one-cycle seeker reset request (RESYNC state)
//   hdr_err_cnt_o  : saturating count of invalid headers seen while LOCKED
module frame_lock_fsm
  import rd53_link_pkg::*;
#(
  parameter int BAD_MAX   = 8,
  parameter int MON_WIN   = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 is_synced,
  input  logic                 frame_vld_i,
  input  logic [1:0]           frame_hdr_i,
  output lock_state_t          state_o,
  output logic                 locked_o,
  output logic                 resync_o,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt_o
);

  localparam int MON_W = $clog2(MON_WIN);
  localparam int BAD_W = $clog2(BAD_MAX + 1);
  localparam logic [MON_W-1:0]     MON_LAST = MON_W'(MON_WIN - 1);
  localparam logic [BAD_W-1:0]     BAD_LIM  = BAD_W'(BAD_MAX);
  localparam logic [MON_W-1:0]     MON_ONE  = MON_W'(1);
  localparam logic [BAD_W-1:0]     BAD_ONE  = BAD_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  lock_state_t          state_q, state_d;
  logic [MON_W-1:0]     mon_cnt_q, mon_cnt_d;
  logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 hdr_bad;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The threshold is checked on the registered bad count,
  // so the frame that reaches BAD_MAX is emitted before RESYNC is entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNLOCKED:    if (is_synced) state_d = LOCKED;
      LOCKED:      if (bad_cnt_q == BAD_LIM) state_d = RESYNC;
      RESYNC:      state_d = WAIT_DESYNC;
      WAIT_DESYNC: if (!is_synced) state_d = UNLOCKED;
      default:     state_d = UNLOCKED;
    endcase
  end

  // Output logic
  always_comb begin
    locked_o = (state_q == LOCKED);
    resync_o = (state_q == RESYNC);
    state_o  = state_q;
  end

  // Monitor counters. A window wrap clears bad_cnt even if the wrapping frame
  // is itself bad; that frame only shows up in the lifetime error count.
  always_comb begin
    mon_cnt_d = mon_cnt_q;
    bad_cnt_d = bad_cnt_q;
    err_cnt_d = err_cnt_q;
    hdr_bad   = !hdr_is_valid(frame_hdr_i);
    if (state_q == UNLOCKED) begin
      if (is_synced) begin
        mon_cnt_d = '0;
        bad_cnt_d = '0;
      end
    end else if ((state_q == LOCKED) && frame_vld_i) begin
      if (hdr_bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_ONE;
      if (mon_cnt_q == MON_LAST) begin
        mon_cnt_d = '0;
        bad_cnt_d = '0;
      end else begin
        mon_cnt_d = mon_cnt_q + MON_ONE;
        if (hdr_bad && (bad_cnt_q != BAD_LIM)) bad_cnt_d = bad_cnt_q + BAD_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mon_cnt_q <= '0;
      bad_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mon_cnt_q <= mon_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hdr_err_cnt_o = err_cnt_q;

endmodule

// File: rtl/frame_extractor.sv
// rtl/frame_extractor.sv - cuts aligned 66-bit frames from the gearbox stream
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   gbox_buffer    : 194-bit gearbox buffer
//   gbox_cnt       : buffer view window index
//   buffer_dv      : gearbox buffer valid (window capture strobe)
//   is_synced      : seeker sync flag
//   offset_pos     : seeker header position 0..65
//   blk_hdr_o      : frame header
//   blk_data_o     : frame payload
//   blk_dv_o       : frame valid, one-cycle pulse
//   is_cmd_o       : header is the command header, qualified by blk_dv_o
//   locked_o       : lock FSM in LOCKED
//   resync_o       : one-cycle seeker reset request
//   hdr_err_cnt_o  : saturating invalid-header count while LOCKED
module frame_extractor
  import rd53_link_pkg::*;
#(
  parameter int BAD_MAX   = 8,
  parameter int MON_WIN   = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [193:0]         gbox_buffer,
  input  logic [5:0]           gbox_cnt,
  input  logic                 buffer_dv,
  input  logic                 is_synced,
  input  logic [6:0]           offset_pos,
  output logic [1:0]           blk_hdr_o,
  output logic [63:0]          blk_data_o,
  output logic                 blk_dv_o,
  output logic                 is_cmd_o,
  output logic                 locked_o,
  output logic                 resync_o,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt_o
);

  logic [SLICE_W-1:0]   w_cur_q, w_cur_d;
  logic [SLICE_W-1:0]   w_prev_q, w_prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic                 pend_q, pend_d;
  logic [6:0]           pos_lat_q, pos_lat_d;
  logic [1:0]           blk_hdr_q, blk_hdr_d;
  logic [63:0]          blk_data_q, blk_data_d;
  logic                 blk_dv_q, blk_dv_d;
  logic                 is_cmd_q, is_cmd_d;

  lock_state_t          state;
  logic                 locked;
  logic                 emit;
  logic [7:0]           slice_top;
  logic [7:0]           cut_top;
  logic [2*SLICE_W-1:0] cat;
  frame_t               cut;

  frame_lock_fsm #(
    .BAD_MAX   (BAD_MAX),
    .MON_WIN   (MON_WIN),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_lock_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .is_synced     (is_synced),
    .frame_vld_i   (emit),
    .frame_hdr_i   (cut.hdr),
    .state_o       (state),
    .locked_o      (locked),
    .resync_o      (resync_o),
    .hdr_err_cnt_o (hdr_err_cnt_o)
  );

  always_comb begin
    // Window capture and history
    slice_top  = 8'd193 - {2'b00, gbox_cnt};
    w_cur_d    = w_cur_q;
    w_prev_d   = w_prev_q;
    prev_vld_d = prev_vld_q;
    if (buffer_dv) begin
      w_cur_d    = gbox_buffer[slice_top -: SLICE_W];
      w_prev_d   = w_cur_q;
      prev_vld_d = 1'b1;
    end
    // Clearing wins over a capture in the same cycle, so the first window
    // after a resync is never paired with stale history.
    if (state == RESYNC) prev_vld_d = 1'b0;

    // A frame is pending once a capture lands on top of a valid window; it is
    // emitted (or dropped) on the following cycle depending on lock state.
    pend_d = buffer_dv && prev_vld_q;

    // Offset tracks the seeker until lock, then stays frozen.
    pos_lat_d = (state == UNLOCKED) ? offset_pos : pos_lat_q;

    // Barrel extraction: the frame occupies cat[68+p : 3+p], header on top.
    cat     = {w_prev_q, w_cur_q};
    cut_top = 8'd68 + {1'b0, pos_lat_q};
    cut     = cat[cut_top -: FRAME_W];

    emit       = pend_q && locked;
    blk_hdr_d  = blk_hdr_q;
    blk_data_d = blk_data_q;
    blk_dv_d   = 1'b0;
    is_cmd_d   = 1'b0;
    if (emit) begin
      blk_hdr_d  = cut.hdr;
      blk_data_d = cut.data;
      blk_dv_d   = 1'b1;
      is_cmd_d   = (cut.hdr == c_CMD_HEADER);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_cur_q    <= '0;
      w_prev_q   <= '0;
      prev_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      pos_lat_q  <= '0;
      blk_hdr_q  <= '0;
      blk_data_q <= '0;
      blk_dv_q   <= 1'b0;
      is_cmd_q   <= 1'b0;
    end else begin
      w_cur_q    <= w_cur_d;
      w_prev_q   <= w_prev_d;
      prev_vld_q <= prev_vld_d;
      pend_q     <= pend_d;
      pos_lat_q  <= pos_lat_d;
      blk_hdr_q  <= blk_hdr_d;
      blk_data_q <= blk_data_d;
      blk_dv_q   <= blk_dv_d;
      is_cmd_q   <= is_cmd_d;
    end
  end

  assign blk_hdr_o  = blk_hdr_q;
  assign blk_data_o = blk_data_q;
  assign blk_dv_o   = blk_dv_q;
  assign is_cmd_o   = is_cmd_q;
  assign locked_o   = locked;

endmodule

// File: doc/frame_extractor.md
Name: frame_extractor

Overview:
- Sits directly downstream of the header seeker.
- Uses the same gearbox slice stream (`gbox_buffer`/`gbox_cnt`/`buffer_dv`) plus the seeker's `is_synced`/`offset_pos` to cut aligned 66-bit frames (2-bit header + 64-bit payload).
- Runs a lock-maintenance FSM that monitors header validity after sync and requests a seeker resync on excessive header errors.
- Output frames feed the command/data decoder.

Parameters:
- BAD_MAX, 8: invalid headers within one monitor window that force loss of lock.
- MON_WIN, 64: monitor window length, in frames.
- ERR_CNT_W, 16: width of the saturating header-error counter.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- gbox_buffer  input  194  complete gearbox buffer
- gbox_cnt  input  6  buffer view window index
- buffer_dv  input  1  valid buffer data
- is_synced  input  1  seeker sync flag
- offset_pos  input  7  seeker header position, 0..65
- blk_hdr_o  output  2  frame header
- blk_data_o  output  64  frame payload
- blk_dv_o  output  1  frame valid, 1-cycle pulse
- is_cmd_o  output  1  header == 2'b10, qualified by blk_dv_o
- locked_o  output  1  FSM in LOCKED
- resync_o  output  1  1-cycle pulse requesting seeker reset
- hdr_err_cnt_o  output  ERR_CNT_W  saturating count of invalid headers seen while LOCKED

Behaviour:
- Reset: all outputs 0, FSM = UNLOCKED, window registers 0, `prev_vld` = 0.
- Window capture: on `buffer_dv`, W_cur <= gbox_buffer[193-gbox_cnt -: 67] and W_prev <= W_cur. `prev_vld` <= 1 after the first capture.
- Concatenation: C = {W_prev, W_cur}, 134 bits. Transmission order is MSB first.
- Extraction (frame cut from W_prev), with p = `pos_lat`:
  - hdr = C[68+p -: 2]
  - data = C[66+p -: 64]
  - Valid for p in 0..65; no index leaves 0..133.
- Output timing:
  - Outputs are registered on the cycle after a `buffer_dv` capture, when `prev_vld` = 1 and FSM = LOCKED.
  - Latency: the frame whose header lies in window k appears one clock after window k+1 is captured.
  - `blk_dv_o` = 1 for exactly one cycle per `buffer_dv`, and only while LOCKED. Otherwise `blk_dv_o` = 0 and the data outputs hold their last value.
- FSM states:
  - UNLOCKED:
    - `pos_lat` <= `offset_pos` every cycle.
    - On `is_synced` = 1 → LOCKED; clear the monitor frame count and window bad count. `pos_lat` stays frozen from this point.
  - LOCKED:
    - Per extracted frame: header not in {01, 10} → `bad_cnt`++ and `hdr_err_cnt_o`++. `hdr_err_cnt_o` saturates at all-ones and is never cleared except by reset.
    - `mon_cnt` counts frames 0..MON_WIN-1.
    - On wrap: `bad_cnt` <= 0, including when the wrap coincides with a bad header; that bad header counts only in `hdr_err_cnt_o`.
    - When `bad_cnt` reaches BAD_MAX → RESYNC. The frame that triggers this is still emitted.
    - `offset_pos` changes while LOCKED are ignored.
  - RESYNC:
    - `resync_o` = 1 for one cycle, `locked_o` = 0, `prev_vld` <= 0.
    - Next cycle → WAIT_DESYNC.
  - WAIT_DESYNC:
    - Stay until `is_synced` = 0 (the seeker has reset), then → UNLOCKED.
    - This prevents relocking on the stale sync flag.
- `locked_o` = 1 exactly in LOCKED.
- Simultaneous events: a `buffer_dv` arriving in the RESYNC cycle updates the windows but emits no frame.
- Reset mid-frame: all state is discarded and no partial frame is emitted.

Decomposition:
- Package `rd53_link_pkg`:
  - `c_DATA_HEADER` = 2'b01, `c_CMD_HEADER` = 2'b10
  - `FRAME_W` = 66, `SLICE_W` = 67
  - `typedef enum logic [1:0] {UNLOCKED, LOCKED, RESYNC, WAIT_DESYNC} lock_state_t`
  - `typedef struct packed {logic [1:0] hdr; logic [63:0] data;} frame_t`
  - The seeker is migrated to share these constants.
- Sub-module `frame_lock_fsm`: state machine, `mon_cnt`, `bad_cnt`, `hdr_err_cnt_o`, `resync_o`.
- The top level keeps the window registers and the barrel extraction.

Test Plan:
- Reset/idle: assert `rst_i` for 3 cycles with `buffer_dv` toggling, `is_synced` = 0 → `blk_dv_o` = 0, `locked_o` = 0 and `hdr_err_cnt_o` = 0 throughout.
- Offset 0 and 65:
  - Stream of frames hdr=01, data=64'hDEADBEEF_CAFEF00D at offset 0.
  - Assert `is_synced` → `locked_o` next cycle; first `blk_dv_o` on the second capture after lock with exact hdr/data.
  - Repeat with `offset_pos` = 65 → identical payload.
- Command flag: hdr=10, data=64'h0123456789ABCDEF → `is_cmd_o` = 1 coincident with `blk_dv_o`; hdr=01 → `is_cmd_o` = 0.
- Loss of lock: locked, inject 8 bad headers (00/11) within 64 frames → 8th frame still emitted with `hdr_err_cnt_o` = 8; `resync_o` pulses once next cycle; `locked_o` = 0.
  - With `is_synced` held 1 → stays WAIT_DESYNC.
  - Drop then reassert `is_synced` → relock.
- Window wrap: 7 bad headers in frames 0..63, then 7 in frames 64..127 → no resync; `hdr_err_cnt_o` = 14.
- Offset change while locked: change `offset_pos` from 10 to 20 mid-stream → extraction stays at offset 10 and frames remain correct.
